// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory controller: FSM state
// encoding and the default byte address of word 0.
package imem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam logic [31:0] IMEM_BASE_ADDR_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x DATA_W, one synchronous write port and one
// synchronous read port. A read and a write to the same index on the same
// edge return the word held before that write.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port plus registered read; nonblocking update gives read-before-write
  always_ff @(posedge clock) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: zero-initialises the array after clear,
// then serves single-cycle-latency fetches and program writes.
// Optional build macro: IMEM_TRACE_EN prints one trace line per response.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR_DEFAULT,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  output logic              busy
);

  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  imem_state_t      state;
  logic [IDX_W-1:0] init_idx;

  // Address decode for the incoming request (stage p0)
  logic [32:0]       off_p0;
  logic              in_range_p0;
  logic              misaligned_p0;
  logic              accept_p0;
  logic [IDX_W-1:0]  ridx_p0;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata_p1;

  logic              vld_p1;
  logic              fault_p1;
  logic              ack_p1;

  assign fetch_ready = (state == RUN);
  assign busy        = (state == INIT);

  assign off_p0        = {1'b0, fetch_addr} - {1'b0, BASE_ADDR};
  assign in_range_p0   = !off_p0[32] && (off_p0 < SPAN);
  assign misaligned_p0 = (fetch_addr[1:0] != 2'b00);
  assign ridx_p0       = off_p0[IDX_W+1:2];
  assign accept_p0     = fetch_req && fetch_ready && !clear;

  // Write port mux: zero-fill while initialising, program writes in RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = prog_idx;
    mem_wdata = prog_data;
    if (!clear) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_widx  = init_idx;
        mem_wdata = '0;
      end else begin
        mem_we    = prog_we;
      end
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .widx  (mem_widx),
    .wdata (mem_wdata),
    .ridx  (ridx_p0),
    .rdata (rdata_p1)
  );

  // FSM: clear restarts zeroing at index 0; leave INIT after the last word
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= INIT;
      init_idx <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == IDX_W'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Stage p0 -> p1: response strobes for accepted fetches and writes
  always_ff @(posedge clock) begin
    if (clear) begin
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      ack_p1   <= 1'b0;
    end else begin
      vld_p1   <= accept_p0;
      fault_p1 <= accept_p0 && (misaligned_p0 || !in_range_p0);
      ack_p1   <= (state == RUN) && prog_we;
    end
  end

  assign fetch_valid = vld_p1;
  assign fetch_fault = vld_p1 && fault_p1;
  assign fetch_instr = (vld_p1 && !fault_p1) ? rdata_p1 : '0;
  assign prog_ack    = ack_p1;

`ifdef IMEM_TRACE_EN
  logic [31:0] addr_p1;

  // Capture the fetched address alongside the response for tracing
  always_ff @(posedge clock) begin
    addr_p1 <= fetch_addr;
  end

  // Trace every response cycle
  always @(posedge clock) begin
    if (fetch_valid) begin
      if (fetch_fault) begin
        $display("Fetch at PC %08x: instruction %08x FAULT", addr_p1, fetch_instr);
      end else begin
        $display("Fetch at PC %08x: instruction %08x", addr_p1, fetch_instr);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with default parameters.
module tb_instr_mem_ctrl;

  logic        clock;
  logic        clear;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        prog_we;
  logic [7:0]  prog_idx;
  logic [31:0] prog_data;
  logic        prog_ack;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_ctrl dut (
    .clock       (clock),
    .clear       (clear),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .prog_we     (prog_we),
    .prog_idx    (prog_idx),
    .prog_data   (prog_data),
    .prog_ack    (prog_ack),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08x expected %08x", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(fetch_valid), 32'd0);
    check({tag, " instr"}, fetch_instr, 32'd0);
    check({tag, " fault"}, 32'(fetch_fault), 32'd0);
    check({tag, " ack"},   32'(prog_ack), 32'd0);
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_instr, input logic exp_fault);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    check({tag, " valid"}, 32'(fetch_valid), 32'd1);
    check({tag, " instr"}, fetch_instr, exp_instr);
    check({tag, " fault"}, 32'(fetch_fault), 32'(exp_fault));
  endtask

  initial begin
    int  cnt;
    logic stray;

    clear      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    prog_we    = 1'b0;
    prog_idx   = 8'd0;
    prog_data  = 32'h0;
    tick();
    clear = 1'b0;

    // State right after clear
    check("rst busy",  32'(busy), 32'd1);
    check("rst ready", 32'(fetch_ready), 32'd0);
    check_idle("rst");

    // Zero-fill duration
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    check("init busy cycles", 32'(cnt), 32'd256);
    check("run ready", 32'(fetch_ready), 32'd1);
    check("run busy",  32'(busy), 32'd0);

    // First fetch after init
    fetch_check("fetch base", 32'h0040_0000, 32'h0, 1'b0);
    tick();
    check_idle("idle after fetch");

    // Program writes
    prog_we = 1'b1; prog_idx = 8'd11; prog_data = 32'h2200_0001;
    tick();
    check("ack idx11", 32'(prog_ack), 32'd1);
    prog_idx = 8'd12; prog_data = 32'h3610_8000;
    tick();
    check("ack idx12", 32'(prog_ack), 32'd1);
    prog_we = 1'b0;
    tick();
    check("ack drop", 32'(prog_ack), 32'd0);

    // Back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 32'h0040_002C;
    tick();
    check("b2b0 valid", 32'(fetch_valid), 32'd1);
    check("b2b0 instr", fetch_instr, 32'h2200_0001);
    fetch_addr = 32'h0040_0030;
    tick();
    fetch_req = 1'b0;
    check("b2b1 valid", 32'(fetch_valid), 32'd1);
    check("b2b1 instr", fetch_instr, 32'h3610_8000);
    check("b2b1 fault", 32'(fetch_fault), 32'd0);
    tick();
    check_idle("idle after b2b");

    // Faulting fetches: just past end, just before base, misaligned
    fetch_check("past end",   32'h0040_0400, 32'h0, 1'b1);
    fetch_check("below base", 32'h003F_FFFC, 32'h0, 1'b1);
    fetch_check("misaligned", 32'h0040_0002, 32'h0, 1'b1);
    fetch_check("last word",  32'h0040_03FC, 32'h0, 1'b0);

    // Read-before-write on the same index
    prog_we = 1'b1; prog_idx = 8'd13; prog_data = 32'hAAAA_5555;
    tick();
    prog_data  = 32'h2210_FFFF;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0034;
    tick();
    prog_we = 1'b0;
    check("rbw old",   fetch_instr, 32'hAAAA_5555);
    check("rbw ack",   32'(prog_ack), 32'd1);
    check("rbw valid", 32'(fetch_valid), 32'd1);
    tick();
    fetch_req = 1'b0;
    check("rbw new",   fetch_instr, 32'h2210_FFFF);

    // Clear mid-INIT with fetch and write held active
    clear = 1'b1;
    tick();
    clear      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0014;
    prog_we    = 1'b1;
    prog_idx   = 8'd5;
    prog_data  = 32'hDEAD_BEEF;
    stray = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fetch_valid || prog_ack || !busy) stray = 1'b1;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("reclear busy", 32'(busy), 32'd1);
    check_idle("reclear");
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      if (fetch_valid || prog_ack) stray = 1'b1;
      cnt++;
      tick();
    end
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    check("reinit busy cycles", 32'(cnt), 32'd256);
    check("init strays", 32'(stray), 32'd0);
    tick();
    check_idle("post reinit");

    // Memory zeroed again and INIT writes ignored
    fetch_check("zeroed idx5",  32'h0040_0014, 32'h0, 1'b0);
    fetch_check("zeroed idx11", 32'h0040_002C, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
